// File: rtl/rng_capture_pkg.sv
// Shared types and default sizing for the random-number generator result path.
package rng_capture_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_TRACK = 2'd2
    } state_t;

endpackage

// File: rtl/rng_history_buf.sv
// Newest-first history of settled results: shift-in on push, flush on clear,
// saturating occupancy count and a combinational indexed read.
module rng_history_buf
    import rng_capture_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [IDX_W:0]    o_count
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    logic [DATA_W-1:0] entry_q [DEPTH];
    logic [DATA_W-1:0] entry_d [DEPTH];
    logic [IDX_W:0]    count_q;
    logic [IDX_W:0]    count_d;

    // Next history contents: clear beats a simultaneous push.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entry_d[k] = entry_q[k];
        end
        count_d = count_q;
        if (i_clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_d[k] = {DATA_W{1'b0}};
            end
            count_d = {(IDX_W+1){1'b0}};
        end else if (i_push) begin
            entry_d[0] = i_data;
            for (int k = 1; k < DEPTH; k++) begin
                entry_d[k] = entry_q[k-1];
            end
            if (count_q == FULL) begin
                count_d = FULL;
            end else begin
                count_d = count_q + {{IDX_W{1'b0}}, 1'b1};
            end
        end else begin
            count_d = count_q;
        end
    end

    // History storage and count registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= {DATA_W{1'b0}};
            end
            count_q <= {(IDX_W+1){1'b0}};
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_q[k] <= entry_d[k];
            end
            count_q <= count_d;
        end
    end

    assign o_rd_valid = ({1'b0, i_rd_idx} < count_q);
    assign o_rd_data  = o_rd_valid ? entry_q[i_rd_idx] : {DATA_W{1'b0}};
    assign o_count    = count_q;

endmodule

// File: rtl/rng_result_capture.sv
// Watches the generator output after a start pulse, captures it once it has
// held steady for SETTLE compares, and aborts tracking after TIMEOUT cycles.
module rng_result_capture
    import rng_capture_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    parameter  int SETTLE  = 8,
    parameter  int TIMEOUT = 1_000_000,
    localparam int IDX_W   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_random,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [IDX_W:0]    o_count,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout
);

    localparam int SC_W = $clog2(SETTLE + 1);
    localparam int TC_W = $clog2(TIMEOUT);
    // Comparing stable_cnt against SETTLE-1 is the same as stable_cnt+1 == SETTLE.
    localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE - 1);
    localparam logic [TC_W-1:0] TMO_LAST    = TC_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [SC_W-1:0]   stable_q, stable_d;
    logic [TC_W-1:0]   tmo_q, tmo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tout_q, tout_d;
    logic              same_s;
    logic              capture_s;
    logic              abort_s;

    assign same_s    = (i_random == prev_q);
    assign capture_s = (state_q == S_TRACK) && !i_start && same_s && (stable_q == SETTLE_LAST);
    assign abort_s   = (state_q == S_TRACK) && !i_start && !capture_s && (tmo_q == TMO_LAST);

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start during tracking re-arms without capturing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: state_d = S_TRACK;
            S_TRACK: begin
                if (i_start) begin
                    state_d = S_ARM;
                end else if (capture_s || abort_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TRACK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tracking datapath and pulse outputs derived from the current state.
    always_comb begin
        prev_d   = prev_q;
        stable_d = stable_q;
        tmo_d    = tmo_q;
        case (state_q)
            S_ARM: begin
                prev_d   = i_random;
                stable_d = {SC_W{1'b0}};
                tmo_d    = {TC_W{1'b0}};
            end
            S_TRACK: begin
                prev_d = i_random;
                tmo_d  = tmo_q + {{(TC_W-1){1'b0}}, 1'b1};
                if (same_s) begin
                    stable_d = stable_q + {{(SC_W-1){1'b0}}, 1'b1};
                end else begin
                    stable_d = {SC_W{1'b0}};
                end
            end
            default: begin
                prev_d   = prev_q;
                stable_d = stable_q;
                tmo_d    = tmo_q;
            end
        endcase
        busy_d = (state_d == S_TRACK);
        done_d = capture_s;
        tout_d = abort_s;
    end

    // Tracking datapath and registered status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_q   <= {DATA_W{1'b0}};
            stable_q <= {SC_W{1'b0}};
            tmo_q    <= {TC_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            stable_q <= stable_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
        end
    end

    rng_history_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_hist (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (capture_s),
        .i_clear    (i_clear),
        .i_data     (i_random),
        .i_rd_idx   (i_rd_idx),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_count    (o_count)
    );

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_timeout = tout_q;

endmodule

// File: tb/tb_rng_result_capture.sv
// Scoreboard bench: stimulus queues expected done/timeout events, a monitor
// pops and checks them whenever the DUT pulses.
module tb_rng_result_capture;

    localparam int DATA_W  = 4;
    localparam int DEPTH   = 4;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 100;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_clear;
    logic [3:0] i_random;
    logic [1:0] i_rd_idx;
    logic [3:0] o_rd_data;
    logic       o_rd_valid;
    logic [2:0] o_count;
    logic       o_busy;
    logic       o_done;
    logic       o_timeout;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit         is_tmo;
        int         cyc;
        logic [3:0] data;
        int         count;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] hist [4];
    int         hcount = 0;

    rng_result_capture #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_clear    (i_clear),
        .i_random   (i_random),
        .i_rd_idx   (i_rd_idx),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_count    (o_count),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic model_push(input logic [3:0] v);
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = v;
        if (hcount < DEPTH) hcount++;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) hist[k] = 4'h0;
        hcount = 0;
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Drive v now; it is first sampled on the next edge and captured SETTLE edges later.
    task automatic settle_on(input logic [3:0] v);
        exp_t e;
        i_random = v;
        model_push(v);
        e = '{is_tmo: 1'b0, cyc: cyc + 1 + SETTLE, data: v, count: hcount};
        exp_q.push_back(e);
        tick(SETTLE + 3);
    endtask

    // Monitor: every done/timeout pulse must match the oldest queued expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst && (o_done || o_timeout)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, o_done, o_timeout}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", {30'd0, o_done, o_timeout}, e.is_tmo ? 1 : 2);
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_count", int'(o_count), e.count);
                chk("pulse_rd0", int'(o_rd_data), int'(e.data));
                chk("pulse_busy", int'(o_busy), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ov_exp [4];
        exp_t       e;
        ov_exp = '{4'h5, 4'h4, 4'h3, 4'h2};
        model_clear();
        i_rst = 1'b1; i_start = 1'b0; i_clear = 1'b0; i_random = 4'h0; i_rd_idx = 2'd0;
        tick(2);
        chk("rst_count", int'(o_count), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_tmo", int'(o_timeout), 0);
        chk("rst_valid", int'(o_rd_valid), 0);
        chk("rst_data", int'(o_rd_data), 0);
        i_rst = 1'b0;
        tick(2);

        // Basic capture after toggling noise.
        start_pulse();
        for (int i = 0; i < 20; i++) begin
            i_random = (i % 2 == 1) ? 4'h9 : 4'h3;
            tick();
        end
        chk("basic_busy", int'(o_busy), 1);
        settle_on(4'hA);
        chk("basic_count", int'(o_count), 1);

        // Near-miss: 8 samples of 5, one 6, then 5 again.
        start_pulse();
        i_random = 4'h5;
        tick(8);
        i_random = 4'h6;
        tick();
        settle_on(4'h5);

        // Overflow: five more captures, oldest dropped.
        for (int v = 1; v <= 5; v++) begin
            start_pulse();
            settle_on(4'(v));
        end
        chk("ovf_count", int'(o_count), 4);
        for (int k = 0; k < 4; k++) begin
            i_rd_idx = 2'(k);
            #1;
            chk("ovf_valid", int'(o_rd_valid), 1);
            chk("ovf_data", int'(o_rd_data), int'(ov_exp[k]));
        end
        i_rd_idx = 2'd0;

        // Asynchronous reset in the middle of tracking.
        start_pulse();
        for (int i = 0; i < 3; i++) begin
            i_random = 4'(i + 1);
            tick();
        end
        chk("mid_busy", int'(o_busy), 1);
        #2;
        i_rst = 1'b1;
        #1;
        model_clear();
        chk("arst_count", int'(o_count), 0);
        chk("arst_busy", int'(o_busy), 0);
        chk("arst_done", int'(o_done), 0);
        for (int k = 0; k < 4; k++) begin
            i_rd_idx = 2'(k);
            #1;
            chk("arst_valid", int'(o_rd_valid), 0);
            chk("arst_data", int'(o_rd_data), 0);
        end
        i_rd_idx = 2'd0;
        tick();
        i_rst = 1'b0;
        tick(2);

        // Timeout: value changes every cycle, history untouched.
        start_pulse();
        settle_on(4'h3);
        e = '{is_tmo: 1'b1, cyc: cyc + 2 + TIMEOUT, data: hist[0], count: hcount};
        exp_q.push_back(e);
        start_pulse();
        for (int i = 0; i < TIMEOUT + 5; i++) begin
            i_random = 4'(i);
            tick();
            if (i == 50) chk("tmo_busy", int'(o_busy), 1);
        end
        chk("tmo_busy_low", int'(o_busy), 0);
        chk("tmo_count", int'(o_count), 1);

        // Restart at stable_cnt=6 restarts the settle count.
        start_pulse();
        i_random = 4'h7;
        tick(7);
        chk("rs_busy", int'(o_busy), 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("rs_arm_busy", int'(o_busy), 0);
        settle_on(4'h7);
        chk("rs_count", int'(o_count), 2);

        // Clear on the same edge as a capture: clear wins.
        start_pulse();
        i_random = 4'hC;
        model_clear();
        e = '{is_tmo: 1'b0, cyc: cyc + 1 + SETTLE, data: 4'h0, count: 0};
        exp_q.push_back(e);
        tick(e.cyc - 1 - cyc);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        tick(3);
        chk("clr_count", int'(o_count), 0);
        chk("clr_valid", int'(o_rd_valid), 0);
        chk("clr_data", int'(o_rd_data), 0);

        tick(3);
        chk("pending_expect", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_result_capture.md
Name: rng_result_capture

Overview:
- Consumer at the far end of the random-number generator's 4-bit output.
- Arms on the generator's start pulse and watches the shuffling value until it stops changing.
- Latches the settled result into a small newest-first history buffer and raises a one-cycle done pulse.
- Provides an indexed read port for the display/LED logic. A timeout catches generators that never settle.

Parameters:
- DATA_W, 4, width of the observed random value.
- DEPTH, 4, history entries (power of 2, ≥2); IDX_W = $clog2(DEPTH).
- SETTLE, 8, consecutive unchanged compares required to declare "settled" (≥1).
- TIMEOUT, 1_000_000, max cycles spent tracking before abort (> SETTLE).

Ports:
- i_clk, in, 1, the single clock.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_start, in, 1, generator-run-started pulse/level; sampled every cycle.
- i_clear, in, 1, synchronous history flush.
- i_random, in, DATA_W, generator output being observed.
- i_rd_idx, in, IDX_W, history index; 0 = newest.
- o_rd_data, out, DATA_W, history entry at i_rd_idx; combinational.
- o_rd_valid, out, 1, i_rd_idx < o_count; combinational.
- o_count, out, IDX_W+1, valid entries, saturates at DEPTH.
- o_busy, out, 1, high while the FSM is in TRACK.
- o_done, out, 1, one-cycle pulse the cycle after a capture.
- o_timeout, out, 1, one-cycle pulse the cycle after a timeout abort.

Behaviour:
- Reset (i_rst high, async):
  - FSM = IDLE.
  - All history entries = 0; o_count = 0.
  - o_busy = o_done = o_timeout = 0.
  - Internal prev-sample, stable counter and timeout counter = 0.
- FSM has states IDLE, ARM, TRACK.
- IDLE:
  - i_start=1 → ARM.
  - Otherwise stay.
- ARM (one cycle):
  - prev ← i_random; stable_cnt ← 0; tmo_cnt ← 0.
  - Next state TRACK.
- TRACK, evaluated every cycle:
  - i_start=1 → restart: go to ARM; nothing captured, no pulse.
  - Else if i_random == prev, stable_cnt+1 == SETTLE:
    - Push i_random into history.
    - Next cycle o_done=1; FSM → IDLE.
  - Else if i_random == prev: stable_cnt++.
  - Else: stable_cnt ← 0.
  - In every case prev ← i_random.
  - tmo_cnt++ each cycle.
  - If tmo_cnt == TIMEOUT-1 with no capture on that edge:
    - Next cycle o_timeout=1; FSM → IDLE; no push.
  - Capture wins over timeout on the same edge.
- Capture latency: after ARM, a value held constant for SETTLE+1 consecutive samples is captured on the edge of the last sample. o_done rises on the next cycle.
- o_busy = (state == TRACK), registered.
- History push:
  - Shift register: entry[k] ← entry[k-1], entry[0] ← value.
  - Oldest entry is dropped when full.
  - o_count = min(o_count+1, DEPTH).
- i_clear:
  - o_count ← 0; entries ← 0; FSM unaffected.
  - Clear together with a push on the same edge: clear wins, and the pushed value is lost.
- Read port:
  - o_rd_data = o_rd_valid ? entry[i_rd_idx] : 0.
  - When o_count == DEPTH, every index is valid.
- Counter widths:
  - stable_cnt is $clog2(SETTLE+1) bits.
  - tmo_cnt is $clog2(TIMEOUT) bits; it never wraps because the FSM exits first.
- i_start held high: the FSM re-arms every TRACK cycle (ARM↔TRACK), so nothing is captured until i_start falls.
- Reset mid-TRACK: everything returns to reset values immediately; no pulse.

Decomposition:
- Package rng_capture_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_ARM, S_TRACK} state_t.
  - Default DATA_W/DEPTH constants shared with the generator top.
- One sub-module, rng_history_buf:
  - DEPTH×DATA_W shift register.
  - Push/clear inputs, saturating count, combinational indexed read.
  - Holds all storage; the FSM stays in the parent.

Test Plan:
1. Reset: i_rst pulse mid-run → o_count=0, o_busy=0, o_rd_data=0 and o_rd_valid=0 for idx 0..3; no o_done.
2. Basic capture (SETTLE=8):
   - Stimulus: i_start 1 cycle; i_random toggles 3,9,3,9 for 20 cycles, then holds 0xA.
   - Response: o_done pulses exactly 1 cycle, 9 cycles after 0xA first appears plus 1 cycle of pulse latency; o_count=1; entry[0]=0xA.
3. Near-miss:
   - Stimulus: hold 0x5 for 8 samples, change to 0x6 for 1, hold 0x5 again.
   - Response: capture only after 9 fresh equal 0x5 samples; stored value 0x5.
4. History overflow:
   - Stimulus: five runs capturing 1,2,3,4,5.
   - Response: o_count=4; idx0..3 = 5,4,3,2; value 1 dropped.
5. Timeout (TIMEOUT=100):
   - Stimulus: i_random changes every cycle after start.
   - Response: o_timeout pulses 1 cycle after 100 TRACK cycles; o_count unchanged; o_busy falls.
6. Restart and clear:
   - Stimulus: i_start re-pulsed at stable_cnt=6 → no capture, the count restarts, and capture occurs SETTLE+1 samples later.
   - Stimulus: i_clear asserted on the same edge as a push → o_count=0; idx0 reads 0, o_rd_valid=0.
